// File: rtl/menu_mode_fsm.sv
// menu_mode_fsm: top-level mode selector for the human-benchmark console.
// It picks which of NUM_MODES games owns the display and issues one-cycle
// start/abort pulses to the game blocks. A key press only arms a game, and
// the game launches when every key is released.
// Optional feature macro: MENU_IDLE_TIMEOUT_EN. When it is defined, a game
// left idle for TIMEOUT_CYCLES cycles is aborted as if iBack had been pressed.
module menu_mode_fsm #(
  parameter int NUM_MODES      = 2,
  parameter int MODE_W         = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 iClock,
  input  logic                 iResetn,
  input  logic [NUM_MODES-1:0] iSelect,
  input  logic                 iBack,
  input  logic                 iGameDone,
  output logic [MODE_W-1:0]    oMode,
  output logic                 oStart,
  output logic                 oAbort,
  output logic [MODE_W-1:0]    oLastMode,
  output logic [2:0]           oCurState
);

  typedef enum logic [2:0] {
    S_MENU     = 3'd0,
    S_ARMED    = 3'd1,
    S_RUN      = 3'd2,
    S_EXIT     = 3'd3,
    S_WAIT_REL = 3'd4
  } state_e;

  state_e            state_q;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] last_mode_q;
  logic [MODE_W-1:0] pend_q;
  logic              start_q;
  logic              abort_q;

  logic              any_sel;
  logic [MODE_W-1:0] sel_mode;
  logic              timeout;

  assign any_sel = |iSelect;

  // Lowest-index pressed key mapped to its game number (key i -> game i+1).
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel_mode = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (iSelect[i]) sel_mode = MODE_W'(i + 1);
    end
  end

`ifdef MENU_IDLE_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt_q;

  // The idle count reaches TIMEOUT_CYCLES on this edge: abort like iBack.
  assign timeout = (state_q == S_RUN) && (idle_cnt_q == CNT_LAST) && !any_sel && !iBack;

  // Count idle cycles while a game runs. The counter is zero outside RUN, so
  // entering RUN always starts the count from zero.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      idle_cnt_q <= '0;
    end else if (state_q == S_RUN && !iGameDone && !iBack && !any_sel && !timeout) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Mode FSM with registered outputs. The pulse outputs default low every cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q     <= S_MENU;
      mode_q      <= '0;
      last_mode_q <= '0;
      pend_q      <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_MENU: begin
          if (any_sel) begin
            pend_q  <= sel_mode;
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (iBack) begin
            state_q <= S_WAIT_REL;
          end else if (!any_sel) begin
            state_q     <= S_RUN;
            mode_q      <= pend_q;
            last_mode_q <= pend_q;
            start_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (iGameDone) begin
            state_q <= S_EXIT;
          end else if (iBack || timeout) begin
            state_q <= S_EXIT;
            abort_q <= 1'b1;
          end
        end
        S_EXIT: begin
          mode_q  <= '0;
          state_q <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!any_sel && !iBack) state_q <= S_MENU;
        end
        default: begin
          state_q <= S_MENU;
          mode_q  <= '0;
        end
      endcase
    end
  end

  assign oMode     = mode_q;
  assign oStart    = start_q;
  assign oAbort    = abort_q;
  assign oLastMode = last_mode_q;
  assign oCurState = state_q;

endmodule

// File: tb/tb_menu_mode_fsm.sv
// Self-checking bench for menu_mode_fsm: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model of the menu. Follows MENU_IDLE_TIMEOUT_EN like the DUT.
module tb_menu_mode_fsm;

  localparam int NM  = 2;
  localparam int MW  = 4;
  localparam int TMO = 10;
`ifdef MENU_IDLE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] sel = '0;
  logic          back = 1'b0;
  logic          done = 1'b0;
  logic [MW-1:0] mode;
  logic          start;
  logic          abort;
  logic [MW-1:0] last;
  logic [2:0]    cur;

  always #5 clk = ~clk;

  menu_mode_fsm #(
    .NUM_MODES      (NM),
    .MODE_W         (MW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .iClock    (clk),
    .iResetn   (rst_n),
    .iSelect   (sel),
    .iBack     (back),
    .iGameDone (done),
    .oMode     (mode),
    .oStart    (start),
    .oAbort    (abort),
    .oLastMode (last),
    .oCurState (cur)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phases are kept as independent facts: a pending game number, whether a
  // game runs, whether we are in the one-cycle exit, whether keys must be
  // released first. The debug code is derived from those facts.
  int m_mode, m_last, m_pend, m_idle;
  bit m_run, m_exit, m_hold, m_start, m_abort;

  function automatic int lowest_game(input logic [NM-1:0] s);
    logic [NM-1:0] iso;
    iso = s & (~s + 1'b1);
    return $clog2(int'(iso)) + 1;
  endfunction

  function automatic int exp_state();
    if (m_exit) return 3;
    if (m_run)  return 2;
    if (m_pend != 0) return 1;
    if (m_hold) return 4;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_last = 0; m_pend = 0; m_idle = 0;
      m_run = 0; m_exit = 0; m_hold = 0; m_start = 0; m_abort = 0;
    end else begin
      m_start = 0;
      m_abort = 0;
      if (m_exit) begin
        m_exit = 0; m_mode = 0; m_hold = 1;
      end else if (m_run) begin
        if (done) begin
          m_run = 0; m_exit = 1;
        end else if (back || (TO_EN && sel == 0 && m_idle + 1 == TMO)) begin
          m_run = 0; m_exit = 1; m_abort = 1;
        end else if (sel != 0) begin
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end else if (m_pend != 0) begin
        if (back) begin
          m_pend = 0; m_hold = 1;
        end else if (sel == 0) begin
          m_run = 1; m_mode = m_pend; m_last = m_pend; m_start = 1;
          m_pend = 0; m_idle = 0;
        end
      end else if (m_hold) begin
        if (sel == 0 && !back) m_hold = 0;
      end else if (sel != 0) begin
        m_pend = lowest_game(sel);
      end
    end
  end

  // Every cycle out of reset: DUT outputs must equal the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [MW-1:0] e_mode, e_last;
      logic [2:0]    e_cur;
      e_mode = MW'(m_mode);
      e_last = MW'(m_last);
      e_cur  = 3'(exp_state());
      n_total++;
      if ({mode, start, abort, last, cur} === {e_mode, m_start, m_abort, e_last, e_cur}) n_pass++;
      else $display("FAIL model t=%0t: mode/start/abort/last/state got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                    $time, mode, start, abort, last, cur, e_mode, m_start, m_abort, e_last, e_cur);
    end
  end

  // Drive inputs for one clock, then return just after the following falling edge.
  task automatic cyc(input logic [NM-1:0] s, input logic b, input logic d);
    sel = s; back = b; done = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // 1: reset state, then iGameDone in MENU changes nothing.
    repeat (2) @(negedge clk);
    #1;
    check("reset_mode", int'(mode), 0);
    check("reset_state", int'(cur), 0);
    check("reset_last", int'(last), 0);
    check("reset_start_abort", int'({start, abort}), 0);
    rst_n = 1'b1;
    cyc(2'b00, 0, 1);
    check("done_in_menu_state", int'(cur), 0);
    check("done_in_menu_mode", int'(mode), 0);

    // 2: hold key 1 for 5 cycles, then release.
    repeat (5) cyc(2'b10, 0, 0);
    check("held_armed", int'(cur), 1);
    check("held_no_start", int'(start), 0);
    cyc(2'b00, 0, 0);
    check("release_start", int'(start), 1);
    check("release_mode", int'(mode), 2);
    check("release_last", int'(last), 2);
    check("release_state", int'(cur), 2);
    cyc(2'b00, 0, 0);
    check("start_one_cycle", int'(start), 0);
    cyc(2'b00, 0, 1);
    check("exit_state", int'(cur), 3);
    check("exit_mode_still", int'(mode), 2);
    cyc(2'b00, 0, 0);
    check("exit_mode_zero", int'(mode), 0);
    check("wait_state", int'(cur), 4);
    cyc(2'b00, 0, 0);
    check("back_menu", int'(cur), 0);

    // 3: both keys together -> lowest index wins.
    cyc(2'b11, 0, 0);
    cyc(2'b00, 0, 0);
    check("lowest_mode", int'(mode), 1);
    check("lowest_last", int'(last), 1);

    // 4: iBack and iGameDone together -> no abort; iBack held keeps WAIT_REL.
    cyc(2'b00, 1, 1);
    check("both_no_abort", int'(abort), 0);
    check("both_exit", int'(cur), 3);
    cyc(2'b00, 1, 0);
    check("both_mode_zero", int'(mode), 0);
    cyc(2'b00, 1, 0);
    check("back_held_wait", int'(cur), 4);
    cyc(2'b00, 0, 0);
    check("back_released_menu", int'(cur), 0);

    // 5: abort via iBack with key 0 held afterwards.
    cyc(2'b10, 0, 0);
    cyc(2'b00, 0, 0);
    cyc(2'b01, 1, 0);
    check("abort_pulse", int'(abort), 1);
    cyc(2'b01, 0, 0);
    check("abort_one_cycle", int'(abort), 0);
    check("abort_mode_zero", int'(mode), 0);
    cyc(2'b01, 0, 0);
    check("held_key_no_retrigger", int'(cur), 4);
    cyc(2'b00, 0, 0);
    cyc(2'b01, 0, 0);
    check("repress_armed", int'(cur), 1);
    cyc(2'b00, 0, 0);
    check("relaunch_mode", int'(mode), 1);
    check("relaunch_start", int'(start), 1);
    cyc(2'b00, 0, 1);
    cyc(2'b00, 0, 0);
    cyc(2'b00, 0, 0);

    // 6: idle timeout (only when the feature is built in).
    if (TO_EN) begin
      cyc(2'b01, 0, 0);
      cyc(2'b00, 0, 0);
      for (int k = 1; k <= TMO; k++) begin
        cyc(2'b00, 0, 0);
        check($sformatf("timeout_k%0d", k), int'(abort), (k == TMO) ? 1 : 0);
      end
      cyc(2'b00, 0, 0);
      cyc(2'b00, 0, 0);
      cyc(2'b01, 0, 0);
      cyc(2'b00, 0, 0);
      for (int k = 1; k <= 17; k++) begin
        cyc((k == 7) ? 2'b10 : 2'b00, 0, 0);
        check($sformatf("retimeout_k%0d", k), int'(abort), (k == 17) ? 1 : 0);
      end
      cyc(2'b00, 0, 0);
      cyc(2'b00, 0, 0);
    end

    // Reset mid-game forces MENU immediately, without an abort pulse.
    cyc(2'b10, 0, 0);
    cyc(2'b00, 0, 0);
    cyc(2'b00, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_mode", int'(mode), 0);
    check("midreset_state", int'(cur), 0);
    check("midreset_abort", int'(abort), 0);
    check("midreset_last", int'(last), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized phase, checked every cycle against the model.
    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      dens = $urandom_range(1, 20);
      for (int c = 0; c < 200; c++) begin
        logic [NM-1:0] s;
        logic b, d;
        s = sel;
        if ($urandom_range(0, dens) == 0) s = NM'($urandom_range(0, (1 << NM) - 1));
        else if ($urandom_range(0, 3) == 0) s = '0;
        b = ($urandom_range(0, dens * 3) == 0);
        d = ($urandom_range(0, dens * 2) == 0);
        if ($urandom_range(0, 999) == 0) begin
          rst_n = 1'b0;
          #1;
          check("rand_reset_mode", int'(mode), 0);
          @(negedge clk);
          #1;
          rst_n = 1'b1;
        end
        cyc(s, b, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
